// File: rtl/fp16_step_pipe.sv
// fp16_step_pipe: 3-stage pipelined floating-point step unit, res = val +/- step.
// Truncating (round-toward-zero) arithmetic, subnormal operands and results flushed to +0.
// Build option: define FP16_STEP_SAT_EN to saturate overflow/Inf results to +/-max finite;
// otherwise they are produced as +/-Inf. out_ovf flags both cases.
// Stage map: S1 unpack/specials/swap/align, S2 add/sub, S3 normalise/pack (output register).

module fp16_step_pipe #(
    parameter int unsigned EXP_WIDTH = 5,
    parameter int unsigned MAN_WIDTH = 10,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sub,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_val,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_step,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out_res,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic                           out_ovf
);

    localparam int unsigned DATA_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
    // Significand: hidden bit + mantissa + 2 guard bits; sum adds a carry bit.
    localparam int unsigned SIG_W = MAN_WIDTH + 3;
    localparam int unsigned SUM_W = MAN_WIDTH + 4;
    localparam int EXP_ALL_ONES = (1 << EXP_WIDTH) - 1;
    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}} | (DATA_WIDTH'(1) << (MAN_WIDTH - 1));

    // Value produced for overflow and for Inf operands.
    function automatic logic [DATA_WIDTH-1:0] ovf_value(input logic sign);
`ifdef FP16_STEP_SAT_EN
        return {sign, {(EXP_WIDTH - 1){1'b1}}, 1'b0, {MAN_WIDTH{1'b1}}};
`else
        return {sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
`endif
    endfunction

    // Single global advance: every stage moves together or holds together.
    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic                  a_sign, b_sign;
    logic [EXP_WIDTH-1:0]  a_exp, b_exp;
    logic [MAN_WIDTH-1:0]  a_man, b_man;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, eff_sub;
    logic [EXP_WIDTH+MAN_WIDTH-1:0] a_mag, b_mag;
    logic [SIG_W-1:0]      a_sig, b_sig;

    logic                  s1_spec_d, s1_spec_ovf_d, s1_sign_d;
    logic [DATA_WIDTH-1:0] s1_spec_res_d;
    logic [EXP_WIDTH-1:0]  s1_exp_d, small_exp, exp_diff;
    logic [SIG_W-1:0]      s1_big_d, small_sig, s1_small_d;

    logic                  s1_valid_q, s1_spec_q, s1_spec_ovf_q, s1_sign_q, s1_sub_q;
    logic [DATA_WIDTH-1:0] s1_spec_res_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;
    logic [EXP_WIDTH-1:0]  s1_exp_q;
    logic [SIG_W-1:0]      s1_big_q, s1_small_q;

    assign a_sign  = in_val[DATA_WIDTH-1];
    assign a_exp   = in_val[MAN_WIDTH +: EXP_WIDTH];
    assign a_man   = in_val[MAN_WIDTH-1:0];
    assign b_sign  = in_step[DATA_WIDTH-1] ^ in_sub;
    assign b_exp   = in_step[MAN_WIDTH +: EXP_WIDTH];
    assign b_man   = in_step[MAN_WIDTH-1:0];
    assign eff_sub = a_sign ^ b_sign;

    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_man == '0);
    assign b_inf  = (b_exp == '1) && (b_man == '0);
    assign a_nan  = (a_exp == '1) && (a_man != '0);
    assign b_nan  = (b_exp == '1) && (b_man != '0);

    // Flushed operands compare as zero magnitude.
    assign a_mag = a_zero ? '0 : in_val[EXP_WIDTH+MAN_WIDTH-1:0];
    assign b_mag = b_zero ? '0 : in_step[EXP_WIDTH+MAN_WIDTH-1:0];
    assign a_sig = a_zero ? '0 : {1'b1, a_man, 2'b00};
    assign b_sig = b_zero ? '0 : {1'b1, b_man, 2'b00};

    // Resolve special operands and order/align the finite path.
    always_comb begin
        s1_spec_d     = 1'b0;
        s1_spec_ovf_d = 1'b0;
        s1_spec_res_d = '0;
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            s1_spec_d     = 1'b1;
            s1_spec_res_d = QNAN;
        end else if (a_inf || b_inf) begin
            s1_spec_d     = 1'b1;
            s1_spec_ovf_d = 1'b1;
            s1_spec_res_d = ovf_value(a_inf ? a_sign : b_sign);
        end

        if (a_mag >= b_mag) begin
            s1_sign_d = a_sign;
            s1_exp_d  = a_exp;
            s1_big_d  = a_sig;
            small_exp = b_exp;
            small_sig = b_sig;
        end else begin
            s1_sign_d = b_sign;
            s1_exp_d  = b_exp;
            s1_big_d  = b_sig;
            small_exp = a_exp;
            small_sig = a_sig;
        end
        exp_diff = s1_exp_d - small_exp;
        if (int'(exp_diff) >= int'(SIG_W)) begin
            s1_small_d = '0;
        end else begin
            s1_small_d = small_sig >> exp_diff;
        end
    end

    // S1 pipeline register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_valid_q    <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_spec_ovf_q <= 1'b0;
            s1_spec_res_q <= '0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_tag_q      <= '0;
            s1_exp_q      <= '0;
            s1_big_q      <= '0;
            s1_small_q    <= '0;
        end else if (adv) begin
            s1_valid_q    <= in_valid;
            s1_spec_q     <= s1_spec_d;
            s1_spec_ovf_q <= s1_spec_ovf_d;
            s1_spec_res_q <= s1_spec_res_d;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= eff_sub;
            s1_tag_q      <= in_tag;
            s1_exp_q      <= s1_exp_d;
            s1_big_q      <= s1_big_d;
            s1_small_q    <= s1_small_d;
        end
    end

    // ---------------- S2: add / subtract ----------------
    logic [SUM_W-1:0]      s2_sum_d, s2_sum_q;
    logic                  s2_valid_q, s2_spec_q, s2_spec_ovf_q, s2_sign_q;
    logic [DATA_WIDTH-1:0] s2_spec_res_q;
    logic [TAG_WIDTH-1:0]  s2_tag_q;
    logic [EXP_WIDTH-1:0]  s2_exp_q;

    // |big| >= |small| so the difference never goes negative.
    always_comb begin
        if (s1_sub_q) begin
            s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        end else begin
            s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
        end
    end

    // S2 pipeline register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s2_valid_q    <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_spec_ovf_q <= 1'b0;
            s2_spec_res_q <= '0;
            s2_sign_q     <= 1'b0;
            s2_tag_q      <= '0;
            s2_exp_q      <= '0;
            s2_sum_q      <= '0;
        end else if (adv) begin
            s2_valid_q    <= s1_valid_q;
            s2_spec_q     <= s1_spec_q;
            s2_spec_ovf_q <= s1_spec_ovf_q;
            s2_spec_res_q <= s1_spec_res_q;
            s2_sign_q     <= s1_sign_q;
            s2_tag_q      <= s1_tag_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= s2_sum_d;
        end
    end

    // ---------------- S3: normalise, truncate, pack ----------------
    int unsigned           lzc;
    int                    exp_n;
    logic [SIG_W-1:0]      norm_sig;
    logic [MAN_WIDTH-1:0]  man_n;
    logic [DATA_WIDTH-1:0] res_d;
    logic                  ovf_d;

    logic                  out_valid_q, out_ovf_q;
    logic [DATA_WIDTH-1:0] out_res_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;

    // Leading-zero count below the carry bit, then normalise and pack.
    always_comb begin
        lzc = SIG_W;
        for (int i = 0; i < int'(SIG_W); i++) begin
            if (s2_sum_q[i]) lzc = SIG_W - 1 - i;
        end
        norm_sig = '0;
        if (s2_sum_q[SUM_W-1]) begin
            exp_n = int'(s2_exp_q) + 1;
            man_n = MAN_WIDTH'(s2_sum_q >> 3);
        end else begin
            norm_sig = s2_sum_q[SIG_W-1:0] << lzc;
            exp_n    = int'(s2_exp_q) - int'(lzc);
            man_n    = MAN_WIDTH'(norm_sig >> 2);
        end

        res_d = '0;
        ovf_d = 1'b0;
        if (s2_spec_q) begin
            res_d = s2_spec_res_q;
            ovf_d = s2_spec_ovf_q;
        end else if (s2_sum_q == '0 || exp_n <= 0) begin
            res_d = '0;
        end else if (exp_n >= EXP_ALL_ONES) begin
            res_d = ovf_value(s2_sign_q);
            ovf_d = 1'b1;
        end else begin
            res_d = {s2_sign_q, EXP_WIDTH'(exp_n), man_n};
        end
    end

    // Output register; data only reloads for valid results so bubbles keep it stable.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_res_q <= res_d;
                out_tag_q <= s2_tag_q;
                out_ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp16_step_pipe.sv
// Directed bench for fp16_step_pipe (default FP16 parameters).
// Expected overflow encodings follow FP16_STEP_SAT_EN when it is defined.

module tb_fp16_step_pipe;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        in_valid, in_ready, in_sub;
    logic [15:0] in_val, in_step;
    logic [7:0]  in_tag;
    logic        out_valid, out_ready;
    logic [15:0] out_res;
    logic [7:0]  out_tag;
    logic        out_ovf;

    always #5 clk = ~clk;

    fp16_step_pipe dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_val    (in_val),
        .in_step   (in_step),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf)
    );

`ifdef FP16_STEP_SAT_EN
    localparam logic [15:0] POS_OVF = 16'h7BFF;
    localparam logic [15:0] NEG_OVF = 16'hFBFF;
`else
    localparam logic [15:0] POS_OVF = 16'h7C00;
    localparam logic [15:0] NEG_OVF = 16'hFC00;
`endif

    typedef struct {
        logic        sub;
        logic [15:0] val;
        logic [15:0] step;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    localparam int N = 18;
    vec_t tbl [N];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [7:0] tag);
        in_valid = 1'b1;
        in_sub   = v.sub;
        in_val   = v.val;
        in_step  = v.step;
        in_tag   = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 16'h3C00, 16'h4000, 16'h4200, 1'b0};  // 1 + 2 = 3
        tbl[1]  = '{1'b1, 16'h3C00, 16'h3C00, 16'h0000, 1'b0};  // exact zero
        tbl[2]  = '{1'b0, 16'h3C00, 16'h0C00, 16'h3C00, 1'b0};  // 2^-12 truncated away
        tbl[3]  = '{1'b0, 16'h0001, 16'h3C00, 16'h3C00, 1'b0};  // subnormal flushed
        tbl[4]  = '{1'b0, 16'h7E00, 16'h3C00, 16'h7E00, 1'b0};  // NaN in
        tbl[5]  = '{1'b1, 16'h7C00, 16'h7C00, 16'h7E00, 1'b0};  // Inf - Inf
        tbl[6]  = '{1'b1, 16'h0400, 16'h0401, 16'h0000, 1'b0};  // underflow
        tbl[7]  = '{1'b0, 16'h7BFF, 16'h7BFF, POS_OVF,  1'b1};  // overflow
        tbl[8]  = '{1'b1, 16'h4000, 16'h3C00, 16'h3C00, 1'b0};  // 2 - 1
        tbl[9]  = '{1'b1, 16'h3C00, 16'h4000, 16'hBC00, 1'b0};  // 1 - 2
        tbl[10] = '{1'b0, 16'hC000, 16'h3C00, 16'hBC00, 1'b0};  // -2 + 1
        tbl[11] = '{1'b0, 16'h3C00, 16'h3C00, 16'h4000, 1'b0};  // carry normalise
        tbl[12] = '{1'b0, 16'h7C00, 16'h3C00, POS_OVF,  1'b1};  // +Inf operand
        tbl[13] = '{1'b1, 16'h3C00, 16'h7C00, NEG_OVF,  1'b1};  // 1 - Inf
        tbl[14] = '{1'b1, 16'h3C01, 16'h3C00, 16'h1400, 1'b0};  // 1 ulp, deep normalise
        tbl[15] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b0};  // -0 + -0 -> +0
        tbl[16] = '{1'b0, 16'h3C00, 16'hFD00, 16'h7E00, 1'b0};  // negative NaN step
        tbl[17] = '{1'b1, 16'hFBFF, 16'h7BFF, NEG_OVF,  1'b1};  // negative overflow

        reset_l   = 1'b0;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_val    = '0;
        in_step   = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_res", 32'(out_res), 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;

        // Single op, latency 3
        @(negedge clk);
        drive(tbl[0], 8'h11);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("lat_valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) begin
                check("lat_res", 32'(out_res), 32'h4200);
                check("lat_tag", 32'(out_tag), 32'h11);
                check("lat_ovf", 32'(out_ovf), 32'd0);
            end
        end

        // Back-to-back stream of the whole table, one result per cycle
        for (int c = 0; c < N + 5; c++) begin
            @(negedge clk);
            if (c >= 3 && c - 3 < N) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_res", 32'(out_res), 32'(tbl[c-3].res));
                check("stream_ovf", 32'(out_ovf), 32'(tbl[c-3].ovf));
                check("stream_tag", 32'(out_tag), 32'(c - 3));
            end else begin
                check("stream_idle", 32'(out_valid), 32'd0);
            end
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (c < N) drive(tbl[c], 8'(c));
            else in_valid = 1'b0;
        end

        // Backpressure: fill with 3 ops, stall 5 cycles, then drain in order
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) drive(tbl[0], 8'h80);
            if (c == 1) drive(tbl[8], 8'h81);
            if (c == 2) drive(tbl[11], 8'h82);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int h = 0; h < 5; h++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_res", 32'(out_res), 32'h4200);
            check("stall_tag", 32'(out_tag), 32'h80);
            @(negedge clk);
        end
        check("stall_hold_res", 32'(out_res), 32'h4200);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("drain_valid", 32'(out_valid), 32'd1);
                check("drain_res", 32'(out_res), 32'h3C00);
                check("drain_tag", 32'(out_tag), 32'h81);
            end else if (k == 2) begin
                check("drain_valid", 32'(out_valid), 32'd1);
                check("drain_res", 32'(out_res), 32'h4000);
                check("drain_tag", 32'(out_tag), 32'h82);
            end else begin
                check("drain_empty", 32'(out_valid), 32'd0);
            end
        end

        // Asynchronous reset with operations in flight
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(tbl[c], 8'(8'hA0 + c));
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 reset_l = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_res", 32'(out_res), 32'd0);
        check("async_reset_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        drive(tbl[14], 8'h5A);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("post_reset_valid", 32'(out_valid), 32'(c == 3));
            if (c == 3) begin
                check("post_reset_res", 32'(out_res), 32'h1400);
                check("post_reset_tag", 32'(out_tag), 32'h5A);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
